acmi_sched: RTL and testbench

Per-fragment sequencing controller for the ACMI minhash pipeline. It accepts each 256-bit fragment from the fragment memory and steps a k-mer window across it. It issues one k-mer per accepted cycle to the hasher, with a running genome-wide k-mer index. It waits for all signatures to return, then runs the sorter and the extender in turn before requesting the next fragment. It sits beside the FragmentMemory → KmerBuffer → Hasher → Sorter → Extender datapath and owns all of that datapath's start, valid and done sequencing.

---
 rtl/acmi_sched.sv | 145 ++++++++++++++
 tb/tb_acmi_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/acmi_sched.sv
// Sequencing controller for the ACMI minhash datapath: steps a k-mer window across
// each fragment, tracks signature returns, then runs sorter and extender in turn.
module acmi_sched #(
    parameter  int FRAG_BYTES = 32,
    parameter  int KMER_BYTES = 16,
    parameter  int IDX_W      = 32,
    localparam int NUM_KMERS  = FRAG_BYTES - KMER_BYTES + 1,
    localparam int OFF_W      = $clog2(NUM_KMERS)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             frag_valid_i,
    input  logic             frag_last_i,
    output logic             frag_ready_o,
    output logic [OFF_W-1:0] kmer_offset_o,
    output logic             kmer_valid_o,
    input  logic             hash_ready_i,
    output logic [IDX_W-1:0] kmer_index_o,
    input  logic             sig_valid_i,
    output logic             sort_start_o,
    input  logic             sort_done_i,
    output logic             ext_start_o,
    input  logic             ext_done_i,
    output logic             busy_o,
    output logic [15:0]      frag_count_o
);

    localparam int RET_W = $clog2(NUM_KMERS + 1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NUM_KMERS - 1);
    localparam logic [RET_W-1:0] RET_FULL = RET_W'(NUM_KMERS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_SORT, S_EXT
    } state_e;

    state_e           state_q, state_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [RET_W-1:0] ret_q, ret_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            ret_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            ret_q   <= ret_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        ret_d   = ret_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        // Returns only count while k-mers are outstanding; extras beyond a full set are dropped.
        if ((state_q == S_SCAN || state_q == S_DRAIN) && sig_valid_i && ret_q != RET_FULL)
            ret_d = ret_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d  = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (frag_valid_i) begin
                    last_d  = frag_last_i;
                    off_d   = '0;
                    ret_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hash_ready_i) begin
                    if (off_q == LAST_OFF) begin
                        off_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (ret_q == RET_FULL) begin
                    base_d  = base_q + IDX_W'(NUM_KMERS);
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                if (sort_done_i) state_d = S_EXT;
            end
            S_EXT: begin
                if (ext_done_i) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 1'b1;
                    state_d = last_q ? S_IDLE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            off_d   = '0;
            ret_d   = '0;
            base_d  = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
        end
    end

    // Marks the first cycle spent in SORT or EXT so the start strobes are single-cycle.
    assign pulse_d = (state_d != state_q) && (state_d == S_SORT || state_d == S_EXT);

    assign frag_ready_o  = (state_q == S_LOAD);
    assign kmer_valid_o  = (state_q == S_SCAN);
    assign kmer_offset_o = (state_q == S_SCAN) ? off_q : '0;
    assign kmer_index_o  = (state_q == S_SCAN) ? (base_q + IDX_W'(off_q)) : '0;
    assign sort_start_o  = (state_q == S_SORT) && pulse_q;
    assign ext_start_o   = (state_q == S_EXT) && pulse_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frag_count_o  = cnt_q;

endmodule

// File: tb/tb_acmi_sched.sv
// Directed bench for acmi_sched: a queue of expected (offset, index) pairs is filled at
// each fragment handshake and drained as the controller presents k-mers.
module tb_acmi_sched;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start, abort, frag_valid, frag_last, frag_ready;
    logic [4:0]  kmer_offset;
    logic        kmer_valid, hash_ready, sig_valid;
    logic [31:0] kmer_index;
    logic        sort_start, sort_done, ext_start, ext_done, busy;
    logic [15:0] frag_count;

    always #5 clk = ~clk;

    acmi_sched dut (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .abort_i(abort),
        .frag_valid_i(frag_valid), .frag_last_i(frag_last), .frag_ready_o(frag_ready),
        .kmer_offset_o(kmer_offset), .kmer_valid_o(kmer_valid), .hash_ready_i(hash_ready),
        .kmer_index_o(kmer_index), .sig_valid_i(sig_valid), .sort_start_o(sort_start),
        .sort_done_i(sort_done), .ext_start_o(ext_start), .ext_done_i(ext_done),
        .busy_o(busy), .frag_count_o(frag_count)
    );

    typedef struct {
        logic [4:0]  off;
        logic [31:0] idx;
    } exp_t;
    exp_t q[$];

    int   total = 0, bad = 0;
    int   cyc = 0, sig_cnt = 0, last_ret_cyc = 0;
    int   sd = 0, ed = 0, xtra_n = 0, ph = 0;
    int   n_sort = 0, n_ext = 0, n_fr = 0;
    logic [31:0] exp_base = 0;
    logic [2:0]  pipe = '0;
    logic [3:0]  pat = 4'b1001;
    bit   acc_flag = 0, fr_prev = 0;
    bit   bp = 0, stray = 0, xtra_mode = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: scoreboard pops, return/pulse bookkeeping.
    initial forever begin
        @(negedge clk);
        if (kmer_valid) begin
            chk("exp_queue", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("kmer_offset", kmer_offset, q[0].off);
                chk("kmer_index", kmer_index, q[0].idx);
                if (hash_ready) void'(q.pop_front());
            end
        end
        acc_flag = kmer_valid && hash_ready;
        if (sig_valid) begin
            sig_cnt++;
            if (sig_cnt == 17) begin
                last_ret_cyc = cyc;
                if (xtra_mode) xtra_n = 2;
            end
        end
        if (sort_start) begin
            n_sort++;
            sd = 5;
            chk("ret_to_sort", 64'(cyc - last_ret_cyc), 2);
        end
        if (ext_start) begin
            n_ext++;
            ed = 5;
        end
        if (frag_ready && !fr_prev) n_fr++;
        fr_prev = frag_ready;
    end

    // Hasher and sorter/extender models: 3-cycle signature return, 5-cycle done.
    initial begin
        hash_ready = 1'b1; sig_valid = 1'b0; sort_done = 1'b0; ext_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            pipe = {pipe[1:0], acc_flag};
            sig_valid = pipe[2] | stray | (xtra_n > 0);
            if (xtra_n > 0) xtra_n--;
            hash_ready = bp ? pat[ph] : 1'b1;
            ph = (ph + 1) % 4;
            sort_done = 1'b0;
            ext_done  = 1'b0;
            if (sd > 0) begin sd--; if (sd == 0) sort_done = 1'b1; end
            if (ed > 0) begin ed--; if (ed == 0) ext_done = 1'b1; end
        end
    end

    task automatic start_run();
        exp_base = 0; n_sort = 0; n_ext = 0; n_fr = 0;
        @(posedge clk); #1; start = 1'b1;
        @(negedge clk); chk("idle_before_start", busy, 0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); chk("start_to_ready", frag_ready, 1);
    endtask

    task automatic feed(input bit last);
        bit ok = 0;
        @(posedge clk); #1; frag_valid = 1'b1; frag_last = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frag_ready) begin ok = 1; break; end
        end
        chk("ready_wait", ok, 1);
        for (int j = 0; j < 17; j++) q.push_back('{off: 5'(j), idx: exp_base + 32'(j)});
        sig_cnt = 0;
        exp_base += 17;
        @(posedge clk); #1; frag_valid = 1'b0; frag_last = 1'b0;
        @(negedge clk); chk("hs_to_valid", kmer_valid, 1);
    endtask

    task automatic wait_end();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frag_ready || !busy) begin ok = 1; break; end
        end
        chk("frag_end_wait", ok, 1);
    endtask

    task automatic run_genome(input int n);
        start_run();
        for (int f = 0; f < n; f++) begin
            feed(f == n - 1);
            wait_end();
        end
        chk("frag_count", frag_count, n);
        chk("busy_end", busy, 0);
        chk("queue_drained", q.size(), 0);
        chk("sort_pulses", n_sort, n);
        chk("ext_pulses", n_ext, n);
        chk("ready_count", n_fr, n);
    endtask

    initial begin
        bit ok, stay;
        reset_ni = 1'b0; start = 1'b0; abort = 1'b0; frag_valid = 1'b0; frag_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_frag_ready", frag_ready, 0);
        chk("rst_kmer_valid", kmer_valid, 0);
        chk("rst_sort_start", sort_start, 0);
        chk("rst_ext_start", ext_start, 0);
        chk("rst_frag_count", frag_count, 0);
        chk("rst_kmer_index", kmer_index, 0);
        chk("rst_kmer_offset", kmer_offset, 0);
        @(posedge clk); #1; reset_ni = 1'b1;

        run_genome(1);
        run_genome(3);

        bp = 1;
        run_genome(1);
        bp = 0;

        repeat (3) begin @(posedge clk); #1; stray = 1'b1; end
        @(posedge clk); #1; stray = 1'b0;
        chk("stray_idle", busy, 0);
        xtra_mode = 1;
        run_genome(1);
        xtra_mode = 0;

        start_run();
        feed(1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (kmer_valid && kmer_offset == 5'd7) begin ok = 1; break; end
        end
        chk("reach_off7", ok, 1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_kmer_valid", kmer_valid, 0);
        chk("abort_kmer_index", kmer_index, 0);
        chk("abort_frag_count", frag_count, 0);
        q.delete();
        repeat (6) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        run_genome(1);

        start_run();
        feed(0);
        wait_end();
        feed(1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sort_start) begin ok = 1; break; end
        end
        chk("reach_sort", ok, 1);
        chk("pre_rst_count", frag_count, 1);
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sort_start", sort_start, 0);
        chk("mid_rst_ext_start", ext_start, 0);
        chk("mid_rst_frag_ready", frag_ready, 0);
        chk("mid_rst_frag_count", frag_count, 0);
        @(posedge clk); #1; reset_ni = 1'b1;
        stay = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || frag_ready || ext_start) stay = 0;
        end
        chk("idle_after_rst", stay, 1);
        run_genome(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
